// File: rtl/ysyx_23060061_mem_arbiter.sv
// N-master to 1-slave memory arbiter: one latched winner is forwarded to the slave and its response routed back.
// Latency: accept T0, slave request T1, slave response T2, master response T3 (min); 1 transaction per 4 cycles.
// Backpressure: s_req_ready / m_resp_ready stalls hold latched fields stable; optional timeout returns an error response.
module ysyx_23060061_mem_arbiter #(
    parameter  int NUM_M       = 2,
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int ARB_MODE    = 0,
    parameter  int TIMEOUT_CYC = 0,
    localparam int MASK_W      = DATA_W / 8,
    localparam int GW          = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_req_valid,
    output logic [NUM_M-1:0]        m_req_ready,
    input  logic [NUM_M-1:0]        m_req_wen,
    input  logic [NUM_M*ADDR_W-1:0] m_req_addr,
    input  logic [NUM_M*DATA_W-1:0] m_req_wdata,
    input  logic [NUM_M*MASK_W-1:0] m_req_wmask,
    output logic [NUM_M-1:0]        m_resp_valid,
    input  logic [NUM_M-1:0]        m_resp_ready,
    output logic [DATA_W-1:0]       m_resp_rdata,
    output logic                    m_resp_err,
    output logic                    s_req_valid,
    input  logic                    s_req_ready,
    output logic                    s_req_wen,
    output logic [ADDR_W-1:0]       s_req_addr,
    output logic [DATA_W-1:0]       s_req_wdata,
    output logic [MASK_W-1:0]       s_req_wmask,
    input  logic                    s_resp_valid,
    output logic                    s_resp_ready,
    input  logic [DATA_W-1:0]       s_resp_rdata,
    output logic [GW-1:0]           grant_id
);

    // Timer only needs to count up to the last cycle before the timeout fires.
    localparam int TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_rr_ptr;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [TW-1:0]       r_timer;

    logic                w_any;
    logic [GW-1:0]       w_win;
    logic [GW-1:0]       w_cand;
    logic                w_timeout;

    // The timeout fires on the TIMEOUT_CYC-th cycle spent in REQ+RESP.
    assign w_timeout = (TIMEOUT_CYC > 0) && (r_timer == TW'(TO_LAST));

    // Winner select: fixed mode scans from index 0, round-robin scans from rr_ptr+1 with wrap.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (ARB_MODE != 0) begin
                w_cand = GW'(k);
            end else begin
                w_cand = GW'((int'(r_rr_ptr) + 1 + k) % NUM_M);
            end
            if (!w_any && m_req_valid[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a timeout in REQ takes precedence over a late slave accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_next = S_REQ;
            S_REQ: begin
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if (s_req_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: if (s_resp_valid || w_timeout) w_next = S_DONE;
            S_DONE: if (m_resp_ready[r_grant]) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; no accept is offered while reset is asserted.
    always_comb begin
        m_req_ready  = '0;
        m_resp_valid = '0;
        s_req_valid  = 1'b0;
        s_resp_ready = 1'b0;
        grant_id     = '0;
        case (r_state)
            S_IDLE: if (rst && w_any) m_req_ready[w_win] = 1'b1;
            S_REQ: begin
                s_req_valid = 1'b1;
                grant_id    = r_grant;
            end
            S_RESP: begin
                s_resp_ready = 1'b1;
                grant_id     = r_grant;
            end
            S_DONE: begin
                m_resp_valid[r_grant] = 1'b1;
                grant_id              = r_grant;
            end
            default: ;
        endcase
    end

    assign s_req_wen    = r_wen;
    assign s_req_addr   = r_addr;
    assign s_req_wdata  = r_wdata;
    assign s_req_wmask  = r_wmask;
    assign m_resp_rdata = r_rdata;
    assign m_resp_err   = r_err;

    // Datapath: latch the winner's request in IDLE, the response in RESP, advance rr_ptr when DONE retires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant  <= '0;
            r_rr_ptr <= GW'(NUM_M - 1);
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_wen   <= m_req_wen[w_win];
                        r_addr  <= m_req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                        r_wdata <= m_req_wdata[int'(w_win)*DATA_W +: DATA_W];
                        r_wmask <= m_req_wmask[int'(w_win)*MASK_W +: MASK_W];
                        r_timer <= '0;
                    end
                end
                S_REQ: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_timer <= r_timer + TW'(1);
                    // A response landing on the timeout cycle still wins.
                    if (s_resp_valid) begin
                        r_rdata <= s_resp_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (m_resp_ready[r_grant]) r_rr_ptr <= r_grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Bench for the memory arbiter: a round-robin instance with timeout and a fixed-priority instance share stimulus.
// Latched expectations are queued at request accept and retired when the master response handshakes.
// Slave model answers with address XOR a key, so 0x80000000 reads back as 0xDEADBEEF.
module tb_ysyx_23060061_mem_arbiter;

    localparam int NM  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam logic [31:0] KEY = 32'h5EAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NM-1:0]     m_req_valid;
    logic [NM-1:0]     m_req_wen;
    logic [AW-1:0]     m_addr [NM];
    logic [NM*AW-1:0]  m_req_addr;
    logic [NM*DW-1:0]  m_req_wdata;
    logic [NM*MW-1:0]  m_req_wmask;
    logic [NM-1:0]     m_resp_ready;
    logic              sl_req_rdy;
    logic              sl_resp_vld;

    for (genvar gi = 0; gi < NM; gi++) begin : g_addr
        assign m_req_addr[gi*AW +: AW] = m_addr[gi];
    end

    logic [NM-1:0] rr_m_req_ready, rr_m_resp_valid, fp_m_req_ready, fp_m_resp_valid;
    logic [DW-1:0] rr_m_resp_rdata, fp_m_resp_rdata, rr_s_req_wdata, fp_s_req_wdata;
    logic          rr_m_resp_err, fp_m_resp_err, rr_s_req_valid, fp_s_req_valid;
    logic          rr_s_req_wen, fp_s_req_wen, rr_s_resp_ready, fp_s_resp_ready;
    logic [AW-1:0] rr_s_req_addr, fp_s_req_addr;
    logic [MW-1:0] rr_s_req_wmask, fp_s_req_wmask;
    logic [DW-1:0] rr_s_resp_rdata, fp_s_resp_rdata;
    logic [0:0]    rr_grant, fp_grant;

    assign rr_s_resp_rdata = rr_s_req_addr ^ KEY;
    assign fp_s_resp_rdata = fp_s_req_addr ^ KEY;

    ysyx_23060061_mem_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYC(8)) u_rr (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(rr_m_req_ready), .m_req_wen(m_req_wen),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
        .m_resp_valid(rr_m_resp_valid), .m_resp_ready(m_resp_ready),
        .m_resp_rdata(rr_m_resp_rdata), .m_resp_err(rr_m_resp_err),
        .s_req_valid(rr_s_req_valid), .s_req_ready(sl_req_rdy), .s_req_wen(rr_s_req_wen),
        .s_req_addr(rr_s_req_addr), .s_req_wdata(rr_s_req_wdata), .s_req_wmask(rr_s_req_wmask),
        .s_resp_valid(sl_resp_vld), .s_resp_ready(rr_s_resp_ready), .s_resp_rdata(rr_s_resp_rdata),
        .grant_id(rr_grant)
    );

    ysyx_23060061_mem_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYC(0)) u_fp (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(fp_m_req_ready), .m_req_wen(m_req_wen),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
        .m_resp_valid(fp_m_resp_valid), .m_resp_ready(m_resp_ready),
        .m_resp_rdata(fp_m_resp_rdata), .m_resp_err(fp_m_resp_err),
        .s_req_valid(fp_s_req_valid), .s_req_ready(sl_req_rdy), .s_req_wen(fp_s_req_wen),
        .s_req_addr(fp_s_req_addr), .s_req_wdata(fp_s_req_wdata), .s_req_wmask(fp_s_req_wmask),
        .s_resp_valid(sl_resp_vld), .s_resp_ready(fp_s_resp_ready), .s_resp_rdata(fp_s_resp_rdata),
        .grant_id(fp_grant)
    );

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   rr_grants[$];
    int   rr_acc_cyc[$];
    int   fp_grants[$];
    int   fp_m1_seen;
    int   checks;
    int   failures;
    int   n_resp;
    int   cyc;
    bit   one_shot;
    bit   exp_timeout;

    // Snapshot of the round-robin instance taken at each negedge
    logic [NM-1:0] sn_req_ready, sn_resp_valid;
    logic          sn_s_req_valid, sn_s_resp_ready, sn_err, sn_s_wen;
    logic [AW-1:0] sn_s_addr;
    logic [DW-1:0] sn_rdata, sn_s_wdata;
    logic [MW-1:0] sn_s_wmask;
    logic [0:0]    sn_grant;

    // One cycle: sample at negedge, record accepts, then update master stimulus just after posedge.
    task automatic tick();
        int   acc;
        exp_t e;
        @(negedge clk);
        cyc++;
        sn_req_ready    = rr_m_req_ready;
        sn_resp_valid   = rr_m_resp_valid;
        sn_s_req_valid  = rr_s_req_valid;
        sn_s_resp_ready = rr_s_resp_ready;
        sn_err          = rr_m_resp_err;
        sn_s_wen        = rr_s_req_wen;
        sn_s_addr       = rr_s_req_addr;
        sn_rdata        = rr_m_resp_rdata;
        sn_s_wdata      = rr_s_req_wdata;
        sn_s_wmask      = rr_s_req_wmask;
        sn_grant        = rr_grant;
        acc = -1;
        for (int i = 0; i < NM; i++) begin
            if (rst && m_req_valid[i] && rr_m_req_ready[i]) acc = i;
            if (rst && m_req_valid[i] && fp_m_req_ready[i]) fp_grants.push_back(i);
        end
        if (fp_m_req_ready[1]) fp_m1_seen++;
        if (acc >= 0) begin
            e.m     = acc;
            e.rdata = exp_timeout ? 32'h0 : (m_addr[acc] ^ KEY);
            e.err   = exp_timeout;
            sb.push_back(e);
            rr_grants.push_back(acc);
            rr_acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (acc >= 0) begin
            m_addr[acc] = m_addr[acc] + 32'd4;
            if (one_shot) m_req_valid[acc] = 1'b0;
        end
    endtask

    // Scoreboard retire: every master response handshake must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            for (int i = 0; i < NM; i++) begin
                if (rr_m_resp_valid[i] && m_resp_ready[i]) begin
                    n_resp++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: response to m%0d rdata=%h err=%b, none expected",
                                 i, rr_m_resp_rdata, rr_m_resp_err);
                    end else begin
                        e = sb.pop_front();
                        if (e.m != i || rr_m_resp_rdata !== e.rdata || rr_m_resp_err !== e.err) begin
                            failures++;
                            $display("FAIL sb_resp: got m%0d rdata=%h err=%b, expected m%0d rdata=%h err=%b",
                                     i, rr_m_resp_rdata, rr_m_resp_err, e.m, e.rdata, e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst          = 1'b0;
        m_req_valid  = '0;
        m_req_wen    = '0;
        m_resp_ready = '1;
        sl_req_rdy   = 1'b1;
        sl_resp_vld  = 1'b1;
        exp_timeout  = 1'b0;
        one_shot     = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
        rr_grants.delete();
        rr_acc_cyc.delete();
        fp_grants.delete();
        fp_m1_seen = 0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        m_req_valid = 2'b11;
        tick();
        tick();
        checks++;
        if ({sn_req_ready, sn_resp_valid, sn_s_req_valid, sn_s_resp_ready, sn_err, sn_s_wen,
             sn_s_addr, sn_rdata, sn_s_wdata, sn_s_wmask, sn_grant} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: req_ready=%b resp_valid=%b s_req_valid=%b s_resp_ready=%b addr=%h grant=%0d, all required 0",
                     sn_req_ready, sn_resp_valid, sn_s_req_valid, sn_s_resp_ready, sn_s_addr, sn_grant);
        end
        m_req_valid = '0;
        rst = 1'b1;
        tick();
        checks++;
        if ({sn_req_ready, sn_s_req_valid, sn_s_resp_ready, sn_resp_valid, sn_grant} !== '0) begin
            failures++;
            $display("FAIL reset_idle: req_ready=%b s_req_valid=%b s_resp_ready=%b resp_valid=%b grant=%0d, required 0",
                     sn_req_ready, sn_s_req_valid, sn_s_resp_ready, sn_resp_valid, sn_grant);
        end
    endtask

    task automatic test_single_read();
        int base;
        do_reset();
        base        = n_resp;
        m_addr[0]   = 32'h8000_0000;
        m_req_valid = 2'b01;
        tick();
        checks++;
        if (sn_req_ready !== 2'b01) begin
            failures++;
            $display("FAIL read_accept_t0: m_req_ready=%b expected 01", sn_req_ready);
        end
        tick();
        checks++;
        if (sn_s_req_valid !== 1'b1 || sn_s_addr !== 32'h8000_0000 || sn_resp_valid !== 2'b00) begin
            failures++;
            $display("FAIL read_sreq_t1: s_req_valid=%b addr=%h resp_valid=%b expected 1 80000000 00",
                     sn_s_req_valid, sn_s_addr, sn_resp_valid);
        end
        tick();
        checks++;
        if (sn_s_resp_ready !== 1'b1 || sn_resp_valid !== 2'b00) begin
            failures++;
            $display("FAIL read_sresp_t2: s_resp_ready=%b resp_valid=%b expected 1 00", sn_s_resp_ready, sn_resp_valid);
        end
        tick();
        checks++;
        if (sn_resp_valid !== 2'b01 || sn_rdata !== 32'hDEAD_BEEF || sn_err !== 1'b0) begin
            failures++;
            $display("FAIL read_resp_t3: resp_valid=%b rdata=%h err=%b expected 01 deadbeef 0",
                     sn_resp_valid, sn_rdata, sn_err);
        end
        tick();
        checks++;
        if (sb.size() != 0 || n_resp - base != 1 || sn_resp_valid !== 2'b00) begin
            failures++;
            $display("FAIL read_retire: pending=%0d responses=%0d resp_valid=%b expected 0 1 00",
                     sb.size(), n_resp - base, sn_resp_valid);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        one_shot    = 1'b0;
        m_addr[0]   = 32'h0000_1000;
        m_addr[1]   = 32'h0000_2000;
        m_req_valid = 2'b11;
        for (int k = 0; k < 40 && rr_grants.size() < 4; k++) tick();
        m_req_valid = '0;
        checks++;
        if (rr_grants.size() < 4) begin
            failures++;
            $display("FAIL rr_grants_count: got %0d grants within budget, expected 4", rr_grants.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rr_grants[k] != k % 2) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: granted m%0d expected m%0d", k, rr_grants[k], k % 2);
                end
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (rr_acc_cyc[k] - rr_acc_cyc[k-1] != 4) begin
                    failures++;
                    $display("FAIL rr_throughput[%0d]: accept spacing %0d cycles expected 4", k,
                             rr_acc_cyc[k] - rr_acc_cyc[k-1]);
                end
            end
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rr_drain: %0d responses outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_fixed_priority();
        bit ok;
        do_reset();
        one_shot    = 1'b0;
        m_req_valid = 2'b11;
        for (int k = 0; k < 40 && fp_grants.size() < 3; k++) tick();
        m_req_valid = '0;
        checks++;
        if (fp_grants.size() < 3) begin
            failures++;
            $display("FAIL fp_grants_count: got %0d grants within budget, expected 3", fp_grants.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (fp_grants[k] != 0) begin
                    failures++;
                    $display("FAIL fp_order[%0d]: granted m%0d expected m0", k, fp_grants[k]);
                end
            end
        end
        checks++;
        if (fp_m1_seen != 0) begin
            failures++;
            $display("FAIL fp_m1_ready: m_req_ready[1] high %0d cycles expected 0", fp_m1_seen);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fp_drain: %0d responses outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        int          base;
        logic [31:0] exp_rd;
        do_reset();
        base        = n_resp;
        m_addr[1]   = 32'h1000_0040;
        exp_rd      = 32'h1000_0040 ^ KEY;
        m_req_wen   = 2'b10;
        m_req_wdata = {32'hCAFE_0001, 32'h1234_5678};
        m_req_wmask = {4'b0011, 4'b1111};
        sl_req_rdy  = 1'b0;
        m_req_valid = 2'b10;
        tick();
        checks++;
        if (sn_req_ready !== 2'b10) begin
            failures++;
            $display("FAIL bp_accept: m_req_ready=%b expected 10", sn_req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (sn_s_req_valid !== 1'b1 || sn_s_addr !== 32'h1000_0040 || sn_s_wen !== 1'b1 ||
                sn_s_wdata !== 32'hCAFE_0001 || sn_s_wmask !== 4'b0011 || sn_grant !== 1'b1) begin
                failures++;
                $display("FAIL bp_sreq_hold[%0d]: valid=%b addr=%h wen=%b wdata=%h wmask=%b grant=%0d expected 1 10000040 1 cafe0001 0011 1",
                         k, sn_s_req_valid, sn_s_addr, sn_s_wen, sn_s_wdata, sn_s_wmask, sn_grant);
            end
        end
        sl_req_rdy   = 1'b1;
        m_resp_ready = 2'b00;
        tick();
        tick();
        checks++;
        if (sn_s_resp_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_resp_state: s_resp_ready=%b expected 1", sn_s_resp_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (sn_resp_valid !== 2'b10 || sn_rdata !== exp_rd || sn_err !== 1'b0) begin
                failures++;
                $display("FAIL bp_mresp_hold[%0d]: resp_valid=%b rdata=%h err=%b expected 10 %h 0",
                         k, sn_resp_valid, sn_rdata, sn_err, exp_rd);
            end
        end
        m_resp_ready = 2'b11;
        tick();
        tick();
        checks++;
        if (sn_resp_valid !== 2'b00 || sb.size() != 0 || n_resp - base != 1) begin
            failures++;
            $display("FAIL bp_complete: resp_valid=%b pending=%0d responses=%0d expected 00 0 1",
                     sn_resp_valid, sb.size(), n_resp - base);
        end
        m_req_wen = '0;
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base        = n_resp;
        exp_timeout = 1'b1;
        sl_resp_vld = 1'b0;
        m_addr[0]   = 32'h8000_0100;
        m_req_valid = 2'b01;
        tick();
        checks++;
        if (sn_req_ready !== 2'b01) begin
            failures++;
            $display("FAIL to_accept: m_req_ready=%b expected 01", sn_req_ready);
        end
        for (int c = 1; c <= 9; c++) begin
            tick();
            checks++;
            if (sn_resp_valid !== ((c == 9) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL to_timing[%0d]: resp_valid=%b expected %b", c, sn_resp_valid,
                         (c == 9) ? 2'b01 : 2'b00);
            end
            if (c == 9) begin
                checks++;
                if (sn_err !== 1'b1 || sn_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL to_error: err=%b rdata=%h expected 1 00000000", sn_err, sn_rdata);
                end
            end
        end
        exp_timeout = 1'b0;
        sl_resp_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (sn_s_resp_ready !== 1'b0 || sn_resp_valid !== 2'b00) begin
                failures++;
                $display("FAIL to_late_resp[%0d]: s_resp_ready=%b resp_valid=%b expected 0 00",
                         k, sn_s_resp_ready, sn_resp_valid);
            end
        end
        checks++;
        if (n_resp - base != 1 || sb.size() != 0) begin
            failures++;
            $display("FAIL to_count: responses=%0d pending=%0d expected 1 0", n_resp - base, sb.size());
        end
    endtask

    task automatic test_reset_mid_resp();
        int base;
        bit ok;
        do_reset();
        sl_resp_vld = 1'b0;
        m_addr[0]   = 32'h8000_0200;
        m_req_valid = 2'b01;
        tick();
        tick();
        tick();
        checks++;
        if (sn_s_resp_ready !== 1'b1) begin
            failures++;
            $display("FAIL mr_in_resp: s_resp_ready=%b expected 1", sn_s_resp_ready);
        end
        base = n_resp;
        rst  = 1'b0;
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        checks++;
        if ({sn_req_ready, sn_resp_valid, sn_s_req_valid, sn_s_resp_ready, sn_err, sn_s_wen,
             sn_s_addr, sn_rdata, sn_s_wdata, sn_s_wmask, sn_grant} !== '0) begin
            failures++;
            $display("FAIL mr_outputs: req_ready=%b resp_valid=%b s_req_valid=%b s_resp_ready=%b addr=%h grant=%0d, all required 0",
                     sn_req_ready, sn_resp_valid, sn_s_req_valid, sn_s_resp_ready, sn_s_addr, sn_grant);
        end
        sl_resp_vld = 1'b1;
        m_addr[1]   = 32'h2000_0000;
        m_req_valid = 2'b10;
        tick();
        checks++;
        if (sn_req_ready !== 2'b10) begin
            failures++;
            $display("FAIL mr_next_accept: m_req_ready=%b expected 10", sn_req_ready);
        end
        tick();
        checks++;
        if (sn_grant !== 1'b1 || sn_s_addr !== 32'h2000_0000) begin
            failures++;
            $display("FAIL mr_next_grant: grant=%0d addr=%h expected 1 20000000", sn_grant, sn_s_addr);
        end
        drain(ok);
        checks++;
        if (!ok || n_resp - base != 1) begin
            failures++;
            $display("FAIL mr_next_done: pending=%0d responses=%0d expected 0 1", sb.size(), n_resp - base);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        n_resp       = 0;
        cyc          = 0;
        fp_m1_seen   = 0;
        rst          = 1'b0;
        m_req_valid  = '0;
        m_req_wen    = '0;
        m_req_wdata  = '0;
        m_req_wmask  = '1;
        m_resp_ready = '1;
        sl_req_rdy   = 1'b1;
        sl_resp_vld  = 1'b1;
        one_shot     = 1'b1;
        exp_timeout  = 1'b0;
        for (int i = 0; i < NM; i++) m_addr[i] = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_timeout();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
